design_17: RTL and testbench



---
 rtl/design_17_pkg.sv | 9 +
 rtl/design_17.sv | 42 ++++
 tb/tb_design_17.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/design_17_pkg.sv
// Shared datapath constants for the design_17 registered adder.
// No timing: constants only.
// No flow control: constants only.
package design_17_pkg;

   // Default operand/result width used when the instantiator does not override W.
   localparam int D17_DEFAULT_W = 12;

endpackage : design_17_pkg

// File: rtl/design_17.sv
// Registered adder: captures (a + b) mod 2^W when start is sampled high.
// Latency 1 clock: sum on y with valid=1 in the cycle after start.
// Never back-pressures: a new request is accepted on every cycle.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (clears y and valid)
//   start  - request strobe, sampled every rising edge
//   a, b   - W-bit operands, sampled with start (don't-care otherwise)
//   y      - registered W-bit sum, holds between requests
//   valid  - registered copy of the previous-cycle start
module design_17
   import design_17_pkg::*;
#(
   parameter int W = D17_DEFAULT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y,
   output logic         valid
);

   // Carry-out falls off the top: the W-bit context truncates the sum.
   logic [W-1:0] sum;
   assign sum = a + b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y     <= '0;
         valid <= 1'b0;
      end else begin
         valid <= start;
         if (start) begin
            y <= sum;
         end
      end
   end

endmodule : design_17

// File: tb/tb_design_17.sv
// Testbench for design_17: scoreboard queue filled by stimulus, drained by a
// negedge monitor that compares valid/y against a plain-arithmetic model.
// Finishes on its own after a fixed number of cycles.
module tb_design_17;

   localparam int W    = 12;
   localparam int MODW = 4096;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] y;
   logic         valid;

   int checks = 0;
   int errors = 0;

   // Expected sums, one entry per start accepted out of reset.
   int exp_q[$];
   // Value y must hold while valid is low.
   int held_y = 0;
   bit done = 0;

   design_17 #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .y     (y),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock of stimulus: drive inputs, wait for the edge, record the
   // expected result if the request was accepted, then step off the edge.
   task automatic cyc(input bit s, input int av, input int bv);
      start = s;
      a     = W'(av);
      b     = W'(bv);
      @(posedge clk);
      if (s && rst_n === 1'b1)
         exp_q.push_back((av + bv) % MODW);
      #1;
   endtask

   // Monitor: outputs are registered, so the falling edge is a safe sample point.
   initial begin
      while (!done) begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            exp_q.delete();
            held_y = 0;
            check("reset_valid", int'(valid), 0);
            check("reset_y", int'(y), 0);
         end else begin
            check("valid_vs_start", int'(valid), (exp_q.size() != 0) ? 1 : 0);
            if (exp_q.size() != 0) begin
               held_y = exp_q.pop_front();
               if (valid === 1'b1)
                  check("sum", int'(y), held_y);
            end else begin
               check("y_hold", int'(y), held_y);
            end
         end
      end
   end

   initial begin
      int av, bv;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #1;

      // Reset held with start asserted: must be ignored.
      repeat (3) cyc(1, 5, 7);
      rst_n = 1'b1;

      // Basic sum, taken on the first edge after release, then hold.
      cyc(1, 'h123, 'h045);
      cyc(0, 0, 0);
      cyc(0, 0, 0);

      // Wrap-around.
      cyc(1, 'hFFF, 'h001);
      cyc(0, 0, 0);
      cyc(1, 'h800, 'h800);
      cyc(0, 0, 0);

      // Back-to-back.
      cyc(1, 1, 2);
      cyc(1, 10, 20);
      cyc(1, 'h3FF, 'h3FF);
      cyc(0, 0, 0);
      cyc(0, 0, 0);

      // Reset mid-operation: pending result dropped, outputs clear at once.
      cyc(1, 'h100, 'h001);
      rst_n = 1'b0;
      #1;
      check("async_reset_valid", int'(valid), 0);
      check("async_reset_y", int'(y), 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      rst_n = 1'b1;
      cyc(0, 0, 0);
      cyc(0, 0, 0);

      // Random pulses, small operands, two idle cycles between.
      repeat (10) begin
         av = int'($urandom_range(0, 1023));
         bv = int'($urandom_range(0, 1023));
         cyc(1, av, bv);
         cyc(0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
         cyc(0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      end

      // Random full-range stream with random start density.
      repeat (60) begin
         av = int'($urandom_range(0, 4095));
         bv = int'($urandom_range(0, 4095));
         cyc(($urandom_range(0, 2) != 0), av, bv);
      end

      cyc(0, 0, 0);
      cyc(0, 0, 0);
      check("scoreboard_drained", exp_q.size(), 0);
      done = 1;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_design_17
